parity_serial_tx: RTL and testbench

//   Sequencer for the even-parity datapath. It accepts a DATA_W-bit word over a

---
 rtl/parity_serial_tx_pkg.sv | 20 ++
 rtl/parity_serial_tx_if.sv | 22 ++
 rtl/parity_serial_tx_even_parity_gen.sv | 9 +
 rtl/parity_serial_tx.sv | 116 +++++++++++
 tb/tb_parity_serial_tx.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/parity_serial_tx_pkg.sv
// Shared types and constants for the even-parity serial transmitter.
package parity_serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Frame bits: start + payload + parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_w);
    return data_w + 32'd3;
  endfunction

endpackage

// File: rtl/parity_serial_tx_if.sv
// Word-in / serial-out bundle between a word producer and the transmitter.
interface parity_serial_tx_if #(
  parameter int unsigned DATA_W = 3
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              tx_out;
  logic              busy;
  logic              frame_done;
  logic              parity_out;

  modport master (
    output in_valid, in_data,
    input  in_ready, tx_out, busy, frame_done, parity_out
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, tx_out, busy, frame_done, parity_out
  );
endinterface

// File: rtl/parity_serial_tx_even_parity_gen.sv
// Even parity of a word: XOR reduction, so ones(data)+parity is always even.
module even_parity_gen #(
  parameter int unsigned DATA_W = 3
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_c_o
);
  assign parity_c_o = ^data_i;
endmodule

// File: rtl/parity_serial_tx.sv
// Serialises one accepted word as start(0), data LSB-first, even parity, stop(1),
// each bit held CLKS_PER_BIT cycles.
module parity_serial_tx
  import parity_serial_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 3,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  parity_serial_tx_if.slave  bus
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                parity_c;
  logic                accept_c;
  logic                bit_end_c;

  even_parity_gen #(.DATA_W(DATA_W)) u_parity (
    .data_i     (bus.in_data),
    .parity_c_o (parity_c)
  );

  assign accept_c  = bus.in_valid && (state_q == ST_IDLE);
  assign bit_end_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= STOP_BIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = STOP_BIT;
    done_d  = 1'b0;

    if (state_q != ST_IDLE) begin
      baud_d = bit_end_c ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_START;
          shift_d = bus.in_data;
          par_d   = parity_c;
        end
      end
      ST_START: begin
        if (bit_end_c) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end_c) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = ST_PARITY;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level and done flag are registered from the upcoming state.
    case (state_d)
      ST_START:  tx_d = START_BIT;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = STOP_BIT;
    endcase
    done_d = (state_d == ST_STOP) && (baud_d == BAUD_W'(CLKS_PER_BIT - 1));
  end

  assign bus.tx_out     = tx_q;
  assign bus.frame_done = done_q;
  assign bus.parity_out = par_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.in_ready   = (state_q == ST_IDLE);

endmodule

// File: tb/tb_parity_serial_tx.sv
// Randomised frame checks of parity_serial_tx against a bit-list model, at 4 and 1 clk/bit.
module tb_parity_serial_tx;
  import parity_serial_tx_pkg::*;

  localparam int unsigned DW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b0;
  logic          valid_r = 1'b0;
  logic [DW-1:0] data_r = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  parity_serial_tx_if #(.DATA_W(DW)) b4 ();
  parity_serial_tx_if #(.DATA_W(DW)) b1 ();

  assign b4.in_valid = valid_r & ~sel;
  assign b4.in_data  = data_r;
  assign b1.in_valid = valid_r & sel;
  assign b1.in_data  = data_r;

  parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) u_dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b4)
  );

  parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b1)
  );

  logic tx_w, ready_w, busy_w, done_w, par_w;
  assign tx_w    = sel ? b1.tx_out     : b4.tx_out;
  assign ready_w = sel ? b1.in_ready   : b4.in_ready;
  assign busy_w  = sel ? b1.busy       : b4.busy;
  assign done_w  = sel ? b1.frame_done : b4.frame_done;
  assign par_w   = sel ? b1.parity_out : b4.parity_out;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (sel=%0d t=%0t): got %0h expected %0h", tag, sel, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".tx"},    32'(tx_w),    32'd1);
    check_eq({tag, ".ready"}, 32'(ready_w), 32'd1);
    check_eq({tag, ".busy"},  32'(busy_w),  32'd0);
    check_eq({tag, ".done"},  32'(done_w),  32'd0);
  endtask

  // Send one word and check the whole frame against the expected bit list.
  // junk: scramble in_valid/in_data while busy; hold: keep in_valid high and
  // present nxt on the last frame cycle.
  task automatic send(input logic [DW-1:0] d, input bit junk, input bit hold,
                      input logic [DW-1:0] nxt);
    int          cpb;
    int          len;
    int          ones;
    int          exp_par;
    logic [DW+2:0] bits;
    cpb     = sel ? 1 : 4;
    len     = int'(frame_bits(DW)) * cpb;
    exp_par = $countones(d) % 2;
    bits    = {1'b1, exp_par[0], d, 1'b0};
    ones    = 0;
    check_idle("pre");
    valid_r = 1'b1;
    data_r  = d;
    tick();
    for (int i = 0; i < len; i++) begin
      check_eq("tx",     32'(tx_w),    32'(bits[i / cpb]));
      check_eq("done",   32'(done_w),  32'(i == len - 1));
      check_eq("busy",   32'(busy_w),  32'd1);
      check_eq("ready",  32'(ready_w), 32'd0);
      check_eq("parity", 32'(par_w),   32'(exp_par));
      if ((i % cpb) == (cpb / 2) && (i / cpb) >= 1 && (i / cpb) <= int'(DW) + 1)
        ones += int'(tx_w);
      if (hold) begin
        valid_r = 1'b1;
        data_r  = (i == len - 1) ? nxt : d;
      end else if (junk && i < len - 1) begin
        valid_r = 1'($urandom_range(0, 1));
        data_r  = DW'($urandom);
      end else begin
        valid_r = 1'b0;
      end
      tick();
    end
    check_eq("even_ones", 32'(ones % 2), 32'd0);
  endtask

  initial begin
    // Reset state on both instances.
    rst = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check_idle("reset");
      check_eq("reset.parity", 32'(par_w), 32'd0);
    end
    sel = 1'b0;
    rst = 1'b0;
    tick();

    send(3'b011, 1'b0, 1'b0, 3'b000);

    // Full payload sweep with the inputs scrambled while busy.
    for (int v = 0; v < 8; v++) send(DW'(v), 1'b1, 1'b0, 3'b000);

    // Back-to-back with in_valid held high.
    send(3'b101, 1'b0, 1'b1, 3'b111);
    send(3'b111, 1'b0, 1'b0, 3'b000);

    // Reset during data bit 1: line returns to idle and no done follows.
    valid_r = 1'b1;
    data_r  = 3'b101;
    tick();
    valid_r = 1'b0;
    repeat (9) tick();
    check_eq("mid.tx_bit1", 32'(tx_w), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("post_rst");
    check_eq("post_rst.parity", 32'(par_w), 32'd0);
    for (int i = 0; i < 30; i++) begin
      check_eq("post_rst.quiet_done", 32'(done_w), 32'd0);
      check_eq("post_rst.quiet_tx",   32'(tx_w),   32'd1);
      tick();
    end

    repeat (12) send(DW'($urandom), 1'($urandom_range(0, 1)), 1'b0, 3'b000);

    // One clock per bit.
    sel = 1'b1;
    #1;
    send(3'b011, 1'b0, 1'b0, 3'b000);
    send(3'b110, 1'b0, 1'b1, 3'b001);
    send(3'b001, 1'b0, 1'b0, 3'b000);
    repeat (10) send(DW'($urandom), 1'($urandom_range(0, 1)), 1'b0, 3'b000);
    check_idle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
